// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : mem_access_unit_pkg                                             |
// | Purpose  : Shared state encoding and access-size codes for the memory      |
// |            access unit and its byte-lane helper.                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mem_access_unit_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_MERGE = 3'd3,
        S_STORE = 3'd4,
        S_ERR   = 3'd5,
        S_RESP  = 3'd6
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_byte_lane.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : byte_lane_unit                                                  |
// | Purpose  : Combinational lane logic. Extracts and extends a byte/half/word |
// |            from a memory word for loads, and builds the read-modify-write  |
// |            word for sub-word stores (little-endian lanes).                 |
// | Ports    : i_rd_word   word read from memory                               |
// |            i_addr_lo   byte offset within the word                         |
// |            i_size      access size code                                    |
// |            i_unsigned  1 = zero-extend loads                               |
// |            i_wdata     right-justified store data                          |
// |            o_load_data extended load result                                |
// |            o_merged    i_rd_word with the addressed lane replaced          |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module byte_lane_unit
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte      = i_rd_word[{i_addr_lo, 3'b000} +: 8];
        w_half      = i_rd_word[{i_addr_lo[1], 4'b0000} +: 16];
        o_load_data = i_rd_word;
        o_merged    = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{24{!i_unsigned & w_byte[7]}}, w_byte};
                o_merged    = i_rd_word;
                o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load_data = {{16{!i_unsigned & w_half[15]}}, w_half};
                o_merged    = i_rd_word;
                o_merged[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_access_unit                                                 |
// | Purpose  : Single-port front end for the unified instruction/data memory.  |
// |            Arbitrates fetch vs. load/store, checks alignment and range,    |
// |            performs sub-word stores as read-modify-write and extends loads.|
// | Ports    : clk, reset (sync, active-high)                                  |
// |            if_req/if_addr  -> if_ready/if_rdata/if_err   fetch port        |
// |            d_req/d_we/d_size/d_unsigned/d_addr/d_wdata                     |
// |                            -> d_ready/d_rdata/d_err      data port         |
// |            mem_addr/mem_we/mem_wdata <- mem_rdata        memory side       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_access_unit #(
    parameter int MEM_WORDS = 512,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ready,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    import mem_access_unit_pkg::*;

    localparam logic [ADDR_W-1:0] C_BYTE_LIMIT = ADDR_W'(MEM_WORDS * 4);

    state_t            r_state;
    logic              r_last_data;
    logic              r_is_fetch;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [31:0]       r_wdata;
    logic [31:0]       r_merged;
    logic              r_if_ready;
    logic [31:0]       r_if_rdata;
    logic              r_if_err;
    logic              r_d_ready;
    logic [31:0]       r_d_rdata;
    logic              r_d_err;

    logic              w_d_err;
    logic              w_if_err;
    logic              w_pick_data;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_d_err  = (d_size == SZ_BAD) || (d_addr >= C_BYTE_LIMIT) ||
                      ((d_size == SZ_HALF) && d_addr[0]) ||
                      ((d_size == SZ_WORD) && (d_addr[1:0] != 2'b00));
    assign w_if_err = (if_addr[1:0] != 2'b00) || (if_addr >= C_BYTE_LIMIT);

    // Data wins a tie unless the previous accept was also data, so a
    // continuously-requesting pair alternates.
    assign w_pick_data = d_req && (!if_req || !r_last_data);

    byte_lane_unit u_lane (
        .i_rd_word   (mem_rdata),
        .i_addr_lo   (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    assign mem_addr  = (r_state == S_IDLE) ? '0 : {r_addr[ADDR_W-1:2], 2'b00};
    // Gated by reset so a reset landing on the STORE cycle kills the write.
    assign mem_we    = (r_state == S_STORE) && !reset;
    assign mem_wdata = (r_size == SZ_WORD) ? r_wdata : r_merged;

    assign if_ready  = r_if_ready;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign d_ready   = r_d_ready;
    assign d_rdata   = r_d_rdata;
    assign d_err     = r_d_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_last_data <= 1'b0;
            r_is_fetch  <= 1'b0;
            r_addr      <= '0;
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_wdata     <= 32'h0;
            r_merged    <= 32'h0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_if_err    <= 1'b0;
            r_d_ready   <= 1'b0;
            r_d_rdata   <= 32'h0;
            r_d_err     <= 1'b0;
        end else begin
            // Ready outputs are single-cycle pulses; they are raised on
            // entry to RESP and drop when RESP is left.
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pick_data) begin
                        r_is_fetch  <= 1'b0;
                        r_last_data <= 1'b1;
                        r_addr      <= d_addr;
                        r_size      <= d_size;
                        r_unsigned  <= d_unsigned;
                        r_wdata     <= d_wdata;
                        r_d_rdata   <= 32'h0;
                        r_d_err     <= 1'b0;
                        if (w_d_err)                r_state <= S_ERR;
                        else if (!d_we)             r_state <= S_LOAD;
                        else if (d_size == SZ_WORD) r_state <= S_STORE;
                        else                        r_state <= S_MERGE;
                    end else if (if_req) begin
                        r_is_fetch  <= 1'b1;
                        r_last_data <= 1'b0;
                        r_addr      <= if_addr;
                        r_size      <= SZ_WORD;
                        r_if_rdata  <= 32'h0;
                        r_if_err    <= 1'b0;
                        r_state     <= w_if_err ? S_ERR : S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_if_rdata <= mem_rdata;
                    r_if_ready <= 1'b1;
                    r_state    <= S_RESP;
                end
                S_LOAD: begin
                    r_d_rdata <= w_load_data;
                    r_d_ready <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_MERGE: begin
                    r_merged <= w_merged;
                    r_state  <= S_STORE;
                end
                S_STORE: begin
                    r_d_ready <= 1'b1;
                    r_state   <= S_RESP;
                end
                S_ERR: begin
                    if (r_is_fetch) begin
                        r_if_err   <= 1'b1;
                        r_if_ready <= 1'b1;
                    end else begin
                        r_d_err   <= 1'b1;
                        r_d_ready <= 1'b1;
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                              |
// | Purpose  : Self-checking bench for mem_access_unit paired with a 512x32    |
// |            memory; directed cases plus randomized traffic compared against |
// |            a word-array reference model.                                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem     [0:511];
    logic [31:0] ref_mem [0:511];
    int          we_cnt;
    int          n_tests;
    int          n_fail;

    mem_access_unit #(.MEM_WORDS(512), .ADDR_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream memory: combinational read, write on posedge.
    assign mem_rdata = mem[mem_addr[10:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[10:2]] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic model_derr(logic [31:0] a, logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if (a >= 32'd2048) return 1'b1;
        if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
        if (sz == 2'b10 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [1:0] sz, logic uns);
        logic [31:0] w;
        logic [31:0] v;
        int sh;
        w = ref_mem[a / 4];
        if (sz == 2'b00) begin
            sh = 8 * int'(a % 4);
            v  = (w >> sh) & 32'hFF;
            if (!uns && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            sh = 16 * int'((a % 4) / 2);
            v  = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic void model_store(logic [31:0] a, logic [1:0] sz, logic [31:0] wd);
        logic [31:0] mask;
        logic [31:0] w;
        int sh;
        w = ref_mem[a / 4];
        if (sz == 2'b00) begin
            sh   = 8 * int'(a % 4);
            mask = 32'hFF << sh;
            w    = (w & ~mask) | ((wd & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh   = 16 * int'((a % 4) / 2);
            mask = 32'hFFFF << sh;
            w    = (w & ~mask) | ((wd & 32'hFFFF) << sh);
        end else begin
            w = wd;
        end
        ref_mem[a / 4] = w;
    endfunction

    // ---------------- transaction tasks ----------------
    task automatic data_op(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_lat;
        int          lat;
        int          we0;
        exp_err = model_derr(addr, sz);
        exp_rd  = (exp_err || we) ? 32'h0 : model_load(addr, sz, uns);
        exp_lat = (we && !exp_err && sz != 2'b10) ? 3 : 2;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_size = sz; d_unsigned = uns; d_addr = addr; d_wdata = wd;
        we0 = we_cnt;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!d_ready && lat < 10);
        d_req = 1'b0;
        chk("d_latency", lat, exp_lat);
        chk("d_err", d_err, exp_err);
        chk("d_rdata", d_rdata, exp_rd);
        rd = d_rdata;
        er = d_err;
        if (we && !exp_err) begin
            model_store(addr, sz, wd);
            chk("store_word", mem[addr / 4], ref_mem[addr / 4]);
            chk("store_we_count", we_cnt - we0, 1);
        end else begin
            chk("no_write", we_cnt - we0, 0);
        end
    endtask

    task automatic fetch_op(input logic [31:0] addr);
        logic        exp_err;
        int          lat;
        exp_err = (addr % 4) != 0 || addr >= 32'd2048;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = addr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!if_ready && lat < 10);
        if_req = 1'b0;
        chk("if_latency", lat, 2);
        chk("if_err", if_err, exp_err);
        chk("if_rdata", if_rdata, exp_err ? 32'h0 : ref_mem[addr / 4]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          seq [4];
        int          n;
        int          cyc;
        int          we0;
        logic [31:0] old;
        n_tests = 0; n_fail = 0; we_cnt = 0;
        reset = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0;
        d_addr = 0; d_wdata = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_err", d_err, 0);
        chk("rst_if_err", if_err, 0);
        reset = 1'b0;

        // word store / load
        data_op(1, 2'b10, 0, 32'h40, 32'hDEADBEEF, rd, er);
        data_op(0, 2'b10, 0, 32'h40, 0, rd, er);
        chk("lw_deadbeef", rd, 32'hDEADBEEF);

        // byte store merge and extended byte loads
        data_op(1, 2'b10, 0, 32'h40, 32'h11223344, rd, er);
        data_op(1, 2'b00, 0, 32'h41, 32'h000000AB, rd, er);
        chk("sb_merged_word", mem[16], 32'h1122AB44);
        data_op(0, 2'b00, 0, 32'h41, 0, rd, er);
        chk("lb_sign", rd, 32'hFFFFFFAB);
        data_op(0, 2'b00, 1, 32'h41, 0, rd, er);
        chk("lbu_zero", rd, 32'h000000AB);

        // halfword store into upper lane
        data_op(1, 2'b10, 0, 32'h40, 32'h0, rd, er);
        data_op(1, 2'b01, 0, 32'h42, 32'h00008001, rd, er);
        chk("sh_merged_word", mem[16], 32'h80010000);
        data_op(0, 2'b01, 0, 32'h42, 0, rd, er);
        chk("lh_sign", rd, 32'hFFFF8001);

        // error cases
        data_op(0, 2'b10, 0, 32'h43, 0, rd, er);
        chk("err_lw_misaligned", er, 1);
        data_op(1, 2'b01, 0, 32'h41, 32'h1234, rd, er);
        chk("err_sh_misaligned", er, 1);
        data_op(0, 2'b10, 0, 32'h800, 0, rd, er);
        chk("err_lw_range", er, 1);
        data_op(1, 2'b11, 0, 32'h44, 32'h1, rd, er);
        chk("err_bad_size", er, 1);
        data_op(0, 2'b10, 0, 32'h7FC, 0, rd, er);
        chk("lw_last_word_ok", er, 0);

        // fetches
        fetch_op(32'h100);
        fetch_op(32'h102);
        fetch_op(32'h800);
        fetch_op(32'h7FC);

        // simultaneous requests alternate D,F,D,F
        @(posedge clk); #1;
        d_req = 1; d_we = 0; d_size = 2'b10; d_unsigned = 0; d_addr = 32'h80;
        if_req = 1; if_addr = 32'h100;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (d_ready) begin
                seq[n] = 0;
                chk("arb_d_rdata", d_rdata, ref_mem[32]);
                n++;
            end else if (if_ready) begin
                seq[n] = 1;
                chk("arb_if_rdata", if_rdata, ref_mem[64]);
                n++;
            end
        end
        d_req = 0; if_req = 0;
        chk("arb_count", n, 4);
        for (int i = 0; i < n; i++) chk("arb_order", seq[i], i % 2);

        // reset during STORE suppresses the write and drops the access
        @(posedge clk); #1;
        old = mem[4];
        we0 = we_cnt;
        d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h10; d_wdata = 32'h55;
        @(posedge clk); #1;
        reset = 1; d_req = 0;
        @(posedge clk); #1;
        chk("rst_store_mem_addr", mem_addr, 0);
        reset = 0;
        chk("rst_store_word", mem[4], old);
        chk("rst_store_we_count", we_cnt - we0, 0);
        n = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (d_ready) n++;
        end
        chk("rst_store_no_ready", n, 0);
        data_op(0, 2'b10, 0, 32'h10, 0, rd, er);

        // randomized traffic
        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) begin
                a = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2200))
                                                : 32'($urandom_range(0, 511) * 4);
                fetch_op(a);
            end else begin
                a = 32'($urandom_range(0, 2200));
                data_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), a, $urandom, rd, er);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
